// File: rtl/fifo_ecc_pkg.sv
// Shared ECC definitions for the FIFO read-side decoder: sizes, check-bit function, position table.
package fifo_ecc_pkg;

    localparam int ECC_NIB = 4;

    typedef enum logic [1:0] {
        SYN_OK,
        SYN_FIX,
        SYN_BAD
    } synStatus_t;

    // Hamming position of data bit i (check bits occupy the powers of two)
    localparam logic [3:0] DATA_POS [8] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};

    function automatic int enc_width(input int dataWidth);
        return dataWidth + dataWidth / 8 * ECC_NIB;
    endfunction

    function automatic logic [3:0] hamming12_check(input logic [7:0] dataByte);
        logic [3:0] chk;
        chk = '0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < ECC_NIB; k++) begin
                if (DATA_POS[i][k]) begin
                    chk[k] = chk[k] ^ dataByte[i];
                end
            end
        end
        return chk;
    endfunction

endpackage

// File: rtl/fifo_ecc_read_port_decoder.sv
// Hamming(12,8) single-byte decoder, purely combinational.
// codeIn = {check nibble, data byte}; flips the data bit named by the syndrome, flags 13..15 as bad.
module ecc_byte_decoder
    import fifo_ecc_pkg::*;
(
    input  logic [11:0] codeIn,
    output logic [7:0]  dataOut,
    output synStatus_t  status
);

    logic [3:0] syndrome;

    always_comb begin
        syndrome = hamming12_check(codeIn[7:0]) ^ codeIn[11:8];
        dataOut  = codeIn[7:0];
        status   = SYN_OK;
        if (syndrome > 4'd12) begin
            status = SYN_BAD;
        end else if (syndrome != 4'd0) begin
            // a syndrome on a check position still counts as a fix, data untouched
            status = SYN_FIX;
            for (int i = 0; i < 8; i++) begin
                if (syndrome == DATA_POS[i]) begin
                    dataOut[i] = ~codeIn[i];
                end
            end
        end
    end

endmodule

// File: rtl/fifo_ecc_read_port.sv
// Drains ECC-encoded FIFO words, corrects per byte, delivers on valid/ready with error stats.
// ReadEn -> OutValid in 2 cycles; 2-entry credit-limited buffer holds data stable under backpressure.
module fifo_ecc_read_port
    import fifo_ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    output logic                                 ReadEn,
    input  logic                                 Empty_,
    input  logic [enc_width(DATA_WIDTH)-1:0]     DataOutEnc,
    output logic [DATA_WIDTH-1:0]                OutData,
    output logic                                 OutValid,
    input  logic                                 OutReady,
    output logic                                 OutCorrected,
    output logic                                 OutUncorrectable,
    output logic [CNT_WIDTH-1:0]                 CorrCount,
    output logic [CNT_WIDTH-1:0]                 UncorrCount,
    output logic                                 Error,
    input  logic                                 ClearErr
);

    localparam int NBYTES = DATA_WIDTH / 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  corr;
        logic                  uncorr;
    } entry_t;

    synStatus_t            byteStatus [NBYTES];
    logic [DATA_WIDTH-1:0] decData;
    logic [NBYTES-1:0]     byteFix;
    logic [NBYTES-1:0]     byteBad;
    entry_t                decoded;
    entry_t                slot0;
    entry_t                slot1;
    logic [1:0]            count;
    logic [1:0]            occupancy;
    logic                  inFlight;
    logic                  pop;

    for (genvar g = 0; g < NBYTES; g++) begin : genDec
        ecc_byte_decoder uDec (
            .codeIn  ({DataOutEnc[DATA_WIDTH + ECC_NIB*g +: ECC_NIB], DataOutEnc[8*g +: 8]}),
            .dataOut (decData[8*g +: 8]),
            .status  (byteStatus[g])
        );
        assign byteFix[g] = (byteStatus[g] == SYN_FIX);
        assign byteBad[g] = (byteStatus[g] == SYN_BAD);
    end

    assign decoded = '{data: decData, corr: |byteFix, uncorr: |byteBad};

    assign OutValid         = (count != 2'd0);
    assign OutData          = slot0.data;
    assign OutCorrected     = slot0.corr;
    assign OutUncorrectable = slot0.uncorr;
    assign pop              = OutValid && OutReady;

    // Buffered count is taken net of this cycle's departure so a draining
    // consumer sees one word per cycle; the in-flight word still holds a slot.
    assign occupancy = count - {1'b0, pop} + {1'b0, inFlight};
    assign ReadEn    = !Reset && Empty_ && (occupancy < 2'd2);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            inFlight    <= 1'b0;
            count       <= 2'd0;
            slot0       <= '0;
            slot1       <= '0;
            CorrCount   <= '0;
            UncorrCount <= '0;
            Error       <= 1'b0;
        end else begin
            inFlight <= ReadEn;

            case ({pop, inFlight})
                2'b10: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) begin
                        slot0 <= decoded;
                    end else begin
                        slot1 <= decoded;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= decoded;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= decoded;
                    end
                end
                default: ;
            endcase

            // statistics follow delivered words, not captured ones
            if (ClearErr) begin
                CorrCount   <= '0;
                UncorrCount <= '0;
                Error       <= 1'b0;
            end else if (pop) begin
                if (slot0.corr && (CorrCount != {CNT_WIDTH{1'b1}})) begin
                    CorrCount <= CorrCount + CNT_WIDTH'(1);
                end
                if (slot0.uncorr && (UncorrCount != {CNT_WIDTH{1'b1}})) begin
                    UncorrCount <= UncorrCount + CNT_WIDTH'(1);
                end
                if (slot0.uncorr) begin
                    Error <= 1'b1;
                end
            end
        end
    end

endmodule
